// File: rtl/quad_decoder.sv
// Quadrature (A/B) encoder decoder with an N-bit up/down position counter.
// Raw encoder pins are synchronized, optionally glitch filtered, and decoded
// as a Gray sequence into step/dir pulses and a wrapping position count.
// Optional glitch filter: define QUAD_FILTER_EN to enable it.
module quad_decoder #(
    parameter int N           = 8,
    parameter int SYNC_STAGES = 2,
    parameter int FILT_CYCLES = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         a_in,
    input  logic         b_in,
    input  logic         syn_clr,
    input  logic         load,
    input  logic [N-1:0] d,
    input  logic         en,
    input  logic         err_clr,
    output logic [N-1:0] pos,
    output logic         step,
    output logic         dir,
    output logic         err,
    output logic         max_tick,
    output logic         min_tick
);

`ifdef QUAD_FILTER_EN
    localparam int PRIME_LEN = SYNC_STAGES + FILT_CYCLES + 1;
`else
    localparam int PRIME_LEN = SYNC_STAGES + 1;
`endif
    localparam int PCW = $clog2(PRIME_LEN + 1);

    typedef enum logic {
        PRIME,
        TRACK
    } state_t;

    state_t               state;
    state_t               state_next;
    logic [PCW-1:0]       prime_cnt;
    logic [SYNC_STAGES-1:0] sync_a;
    logic [SYNC_STAGES-1:0] sync_b;
    logic [1:0]           raw_ab;
    logic [1:0]           cur_ab;
    logic [1:0]           prev_ab;
    logic                 prime_last;
    logic                 prev_load;
    logic                 fwd;
    logic                 rev;
    logic                 ill;

    // Multi-flop synchronizers bring the asynchronous encoder pins into clk.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_a <= '0;
            sync_b <= '0;
        end else begin
            sync_a <= {sync_a[SYNC_STAGES-2:0], a_in};
            sync_b <= {sync_b[SYNC_STAGES-2:0], b_in};
        end
    end

    assign raw_ab = {sync_a[SYNC_STAGES-1], sync_b[SYNC_STAGES-1]};

`ifdef QUAD_FILTER_EN
    localparam int FCW = $clog2(FILT_CYCLES + 1);

    logic [1:0]     filt_ab;
    logic [FCW-1:0] filt_cnt [2];

    // Each channel only follows the synced value after it has disagreed for FILT_CYCLES cycles in a row.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            filt_ab <= '0;
            for (int i = 0; i < 2; i++) begin
                filt_cnt[i] <= '0;
            end
        end else if (state == PRIME) begin
            filt_ab <= raw_ab;
            for (int i = 0; i < 2; i++) begin
                filt_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (raw_ab[i] != filt_ab[i]) begin
                    if (filt_cnt[i] == FCW'(FILT_CYCLES - 1)) begin
                        filt_ab[i]  <= raw_ab[i];
                        filt_cnt[i] <= '0;
                    end else begin
                        filt_cnt[i] <= filt_cnt[i] + 1'b1;
                    end
                end else begin
                    filt_cnt[i] <= '0;
                end
            end
        end
    end

    assign cur_ab = filt_ab;
`else
    assign cur_ab = raw_ab;
`endif

    // State register plus the PRIME flush counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= PRIME;
            prime_cnt <= '0;
        end else begin
            state <= state_next;
            if (state == PRIME && !prime_last) begin
                prime_cnt <= prime_cnt + 1'b1;
            end else begin
                prime_cnt <= '0;
            end
        end
    end

    // Next state and Gray-code decode of the previous/current channel pair.
    always_comb begin
        state_next = state;
        prime_last = 1'b0;
        prev_load  = 1'b0;
        fwd        = 1'b0;
        rev        = 1'b0;
        ill        = 1'b0;
        case (state)
            PRIME: begin
                if (prime_cnt == PCW'(PRIME_LEN - 1)) begin
                    prime_last = 1'b1;
                    prev_load  = 1'b1;
                    state_next = TRACK;
                end
            end
            TRACK: begin
                prev_load = 1'b1;
                case ({prev_ab, cur_ab})
                    4'b0001, 4'b0111, 4'b1110, 4'b1000: fwd = 1'b1;
                    4'b0010, 4'b1011, 4'b1101, 4'b0100: rev = 1'b1;
                    4'b0011, 4'b1100, 4'b0110, 4'b1001: ill = 1'b1;
                    default: ;
                endcase
            end
            default: state_next = PRIME;
        endcase
    end

    // Remember the channel pair so the next cycle can see what changed.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_ab <= '0;
        end else if (prev_load) begin
            prev_ab <= cur_ab;
        end
    end

    // Registered step pulse, direction of last valid step and sticky error (set beats clear).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            step <= 1'b0;
            dir  <= 1'b0;
            err  <= 1'b0;
        end else begin
            step <= fwd | rev;
            if (fwd) begin
                dir <= 1'b1;
            end else if (rev) begin
                dir <= 1'b0;
            end
            if (ill) begin
                err <= 1'b1;
            end else if (err_clr) begin
                err <= 1'b0;
            end
        end
    end

    // Position counter: clear, then load, then enabled counting; wraps modulo 2^N.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pos <= '0;
        end else if (syn_clr) begin
            pos <= '0;
        end else if (load) begin
            pos <= d;
        end else if (en && fwd) begin
            pos <= pos + 1'b1;
        end else if (en && rev) begin
            pos <= pos - 1'b1;
        end
    end

    assign max_tick = (pos == {N{1'b1}});
    assign min_tick = (pos == '0);

endmodule
